// File: rtl/sdram_avalon_arbiter_pkg.sv
// Shared definitions for the SDRAM Avalon arbiter: master ids and default widths.
package sdram_avalon_arbiter_pkg;

  typedef enum logic {
    M0_ID = 1'b0,
    M1_ID = 1'b1
  } master_id_t;

  localparam int unsigned ADDR_W_DEF = 22;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BE_W_DEF   = 2;
  localparam int unsigned PEND_D_DEF = 8;

  // Round-robin tie break: the master not accepted last wins.
  function automatic master_id_t rr_pick(input master_id_t last);
    return (last == M0_ID) ? M1_ID : M0_ID;
  endfunction

endpackage

// File: rtl/sdram_avalon_arbiter_tag_fifo.sv
// Synchronous tag FIFO recording the owner of each outstanding read.
module sdram_arb_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller slave port,
// with combinational command pass-through and in-order read-data steering.
module sdram_avalon_arbiter
  import sdram_avalon_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BE_W   = BE_W_DEF,
  parameter int unsigned PEND_D = PEND_D_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_rd_n,
  input  logic              m0_wr_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic [BE_W-1:0]   m0_be_n,
  output logic              m0_wait_req,
  output logic              m0_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_rd_n,
  input  logic              m1_wr_n,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic [BE_W-1:0]   m1_be_n,
  output logic              m1_wait_req,
  output logic              m1_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_rd_n,
  output logic              s_wr_n,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  output logic [BE_W-1:0]   s_be_n,
  input  logic              s_wait_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        o_grant,
  output logic              o_error
);

  localparam int unsigned CNT_W = $clog2(PEND_D) + 1;

  master_id_t rr_last, lock_id, gnt_id, head_id;
  logic       lock_vld, gnt_vld, req0, req1;
  logic       g_rd_n, g_wr_n, g_rd, g_wr, accept;
  logic       fifo_full, fifo_empty;
  logic [0:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  assign req0 = ~m0_rd_n | ~m0_wr_n;
  assign req1 = ~m1_rd_n | ~m1_wr_n;

  // A lock whose owner dropped its strobe is simply ignored, which is the abandon case.
  always_comb begin
    gnt_vld = 1'b1;
    gnt_id  = M0_ID;
    if (lock_vld && ((lock_id == M1_ID) ? req1 : req0)) gnt_id = lock_id;
    else if (req0 && req1)                               gnt_id = rr_pick(rr_last);
    else if (req1)                                       gnt_id = M1_ID;
    else if (!req0)                                      gnt_vld = 1'b0;
  end

  always_comb begin
    g_rd_n = 1'b1;
    g_wr_n = 1'b1;
    s_addr = '0;
    s_data = '0;
    s_be_n = '0;
    if (gnt_vld) begin
      g_rd_n = (gnt_id == M1_ID) ? m1_rd_n : m0_rd_n;
      g_wr_n = (gnt_id == M1_ID) ? m1_wr_n : m0_wr_n;
      s_addr = (gnt_id == M1_ID) ? m1_addr : m0_addr;
      s_data = (gnt_id == M1_ID) ? m1_data : m0_data;
      s_be_n = (gnt_id == M1_ID) ? m1_be_n : m0_be_n;
    end
  end

  assign g_rd   = gnt_vld & ~g_rd_n;
  assign g_wr   = gnt_vld & g_rd_n & ~g_wr_n;
  assign s_rd_n = ~(g_rd & ~fifo_full);
  assign s_wr_n = ~g_wr;
  assign accept = ~s_wait_req & (~s_rd_n | ~s_wr_n);

  assign o_grant = {gnt_vld & (gnt_id == M1_ID), gnt_vld & (gnt_id == M0_ID)};

  always_comb begin
    m0_wait_req = req0 ? 1'b1 : s_wait_req;
    m1_wait_req = req1 ? 1'b1 : s_wait_req;
    if (gnt_vld && gnt_id == M0_ID) m0_wait_req = s_wait_req | (g_rd & fifo_full);
    if (gnt_vld && gnt_id == M1_ID) m1_wait_req = s_wait_req | (g_rd & fifo_full);
  end

  assign head_id  = master_id_t'(fifo_dout);
  assign m0_valid = s_valid & ~fifo_empty & (head_id == M0_ID);
  assign m1_valid = s_valid & ~fifo_empty & (head_id == M1_ID);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  sdram_arb_tag_fifo #(
    .WIDTH (1),
    .DEPTH (PEND_D)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & g_rd),
    .din     (gnt_id),
    .pop     (s_valid),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last  <= M1_ID;
      lock_vld <= 1'b0;
      lock_id  <= M0_ID;
      o_error  <= 1'b0;
    end else begin
      lock_vld <= gnt_vld & ~accept;
      lock_id  <= gnt_id;
      if (accept) rr_last <= gnt_id;
      o_error  <= o_error | (s_valid & fifo_empty)
                | (~m0_rd_n & ~m0_wr_n) | (~m1_rd_n & ~m1_wr_n);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
                                  fifo_count <= CNT_W'(PEND_D));

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Self-checking bench for sdram_avalon_arbiter: vector table, directed corner cases, random vs model.
module tb_sdram_avalon_arbiter;

  localparam int PEND = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_n [2];
  logic        wr_n [2];
  logic [21:0] addr [2];
  logic [15:0] wdat [2];
  logic [1:0]  be_n [2];
  logic        s_wait_req = 1'b0, s_valid = 1'b0;
  logic [15:0] s_rdata = '0;

  logic        m0_wait_req, m0_valid, m1_wait_req, m1_valid;
  logic [15:0] m0_rdata, m1_rdata, s_data;
  logic        s_rd_n, s_wr_n, o_error;
  logic [21:0] s_addr;
  logic [1:0]  s_be_n, o_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_avalon_arbiter #(
    .ADDR_W (22),
    .DATA_W (16),
    .BE_W   (2),
    .PEND_D (PEND)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_rd_n     (rd_n[0]),
    .m0_wr_n     (wr_n[0]),
    .m0_addr     (addr[0]),
    .m0_data     (wdat[0]),
    .m0_be_n     (be_n[0]),
    .m0_wait_req (m0_wait_req),
    .m0_valid    (m0_valid),
    .m0_rdata    (m0_rdata),
    .m1_rd_n     (rd_n[1]),
    .m1_wr_n     (wr_n[1]),
    .m1_addr     (addr[1]),
    .m1_data     (wdat[1]),
    .m1_be_n     (be_n[1]),
    .m1_wait_req (m1_wait_req),
    .m1_valid    (m1_valid),
    .m1_rdata    (m1_rdata),
    .s_rd_n      (s_rd_n),
    .s_wr_n      (s_wr_n),
    .s_addr      (s_addr),
    .s_data      (s_data),
    .s_be_n      (s_be_n),
    .s_wait_req  (s_wait_req),
    .s_valid     (s_valid),
    .s_rdata     (s_rdata),
    .o_grant     (o_grant),
    .o_error     (o_error)
  );

  typedef struct {
    logic [5:0] in;   // {m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n, s_wait_req, s_valid}
    logic [7:0] exp;  // {s_rd_n, s_wr_n, o_grant, m0_wait_req, m1_wait_req, m0_valid, m1_valid}
  } vec_t;

  vec_t tbl [11];

  // Reference model state
  int q[$];
  int rr_last;
  bit lock_vld;
  int lock_id;
  bit err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] v);
    {rd_n[0], wr_n[0], rd_n[1], wr_n[1], s_wait_req, s_valid} = v;
  endtask

  function automatic logic [7:0] ctl();
    return {s_rd_n, s_wr_n, o_grant, m0_wait_req, m1_wait_req, m0_valid, m1_valid};
  endfunction

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(6'b11_11_0_0);
    reset_n = 1'b0;
    next();
    next();
    reset_n = 1'b1;
    next();
  endtask

  task automatic model_reset();
    q.delete();
    rr_last  = 1;
    lock_vld = 1'b0;
    lock_id  = 0;
    err      = 1'b0;
  endtask

  // One random cycle: inputs already driven, settled; compare then advance model and clock.
  task automatic model_cycle();
    bit req[2];
    bit gv, isrd, full, acc;
    int g;
    logic ew[2];
    logic ev[2];
    logic e_rd_n, e_wr_n;
    for (int i = 0; i < 2; i++) req[i] = !rd_n[i] || !wr_n[i];
    gv = 1'b1;
    g  = 0;
    if (lock_vld && req[lock_id])  g = lock_id;
    else if (req[0] && req[1])     g = (rr_last == 0) ? 1 : 0;
    else if (req[0])               g = 0;
    else if (req[1])               g = 1;
    else                           gv = 1'b0;
    isrd   = gv && !rd_n[g];
    full   = (q.size() == PEND);
    e_rd_n = !(isrd && !full);
    e_wr_n = !(gv && !isrd);
    for (int i = 0; i < 2; i++) begin
      if (gv && g == i) ew[i] = s_wait_req | (isrd && full);
      else              ew[i] = req[i] ? 1'b1 : s_wait_req;
      ev[i] = s_valid && q.size() > 0 && q[0] == i;
    end
    check("rnd_ctl", ctl(),
          {e_rd_n, e_wr_n, gv && g == 1, gv && g == 0, ew[0], ew[1], ev[0], ev[1]});
    check("rnd_bus", {s_addr, s_data, s_be_n},
          gv ? {addr[g], wdat[g], be_n[g]} : 40'h0);
    check("rnd_rdata", {m0_rdata, m1_rdata}, {s_rdata, s_rdata});
    check("rnd_error", o_error, err);
    acc = gv && !s_wait_req && (!isrd || !full);
    if (s_valid && q.size() == 0) err = 1'b1;
    for (int i = 0; i < 2; i++) if (!rd_n[i] && !wr_n[i]) err = 1'b1;
    if (s_valid && q.size() > 0) void'(q.pop_front());
    if (acc && isrd) q.push_back(g);
    lock_vld = gv && !acc;
    lock_id  = g;
    if (acc) rr_last = g;
  endtask

  initial begin
    addr[0] = 22'h000010; wdat[0] = 16'h0010; be_n[0] = 2'b00;
    addr[1] = 22'h000020; wdat[1] = 16'h0020; be_n[1] = 2'b01;
    set_in(6'b11_11_0_0);

    tbl[0]  = '{6'b10_11_0_0, 8'b1_0_01_0_0_0_0};
    tbl[1]  = '{6'b11_11_0_0, 8'b1_1_00_0_0_0_0};
    tbl[2]  = '{6'b11_11_1_0, 8'b1_1_00_1_1_0_0};
    tbl[3]  = '{6'b01_01_0_0, 8'b0_1_10_1_0_0_0};
    tbl[4]  = '{6'b01_11_0_0, 8'b0_1_01_0_0_0_0};
    tbl[5]  = '{6'b11_11_0_1, 8'b1_1_00_0_0_0_1};
    tbl[6]  = '{6'b11_11_0_1, 8'b1_1_00_0_0_1_0};
    tbl[7]  = '{6'b01_10_1_0, 8'b1_0_10_1_1_0_0};
    tbl[8]  = '{6'b01_10_0_0, 8'b1_0_10_1_0_0_0};
    tbl[9]  = '{6'b01_11_0_0, 8'b0_1_01_0_0_0_0};
    tbl[10] = '{6'b11_11_0_1, 8'b1_1_00_0_0_1_0};

    // Reset state
    reset_n = 1'b0;
    next();
    check("rst_ctl", ctl(), 8'b1_1_00_0_0_0_0);
    check("rst_error", o_error, 1'b0);
    reset_n = 1'b1;
    next();

    // Vector table (entry 0 is the single M0 write)
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].in);
      #1;
      check($sformatf("vec%0d", i), ctl(), tbl[i].exp);
      if (i == 0) check("vec0_bus", {s_addr, s_data, s_be_n}, {22'h000010, 16'h0010, 2'b00});
      next();
    end
    check("vec_error", o_error, 1'b0);

    // Simultaneous reads after reset: M0 first, responses steered in order
    do_reset();
    set_in(6'b01_01_0_0); #1;
    check("tie_first", {o_grant, s_rd_n, m0_wait_req, m1_wait_req}, {2'b01, 1'b0, 1'b0, 1'b1});
    check("tie_addr", s_addr, 22'h000010);
    next();
    set_in(6'b11_01_0_0); #1;
    check("tie_second", {o_grant, s_rd_n, m1_wait_req}, {2'b10, 1'b0, 1'b0});
    check("tie_addr2", s_addr, 22'h000020);
    next();
    set_in(6'b11_11_0_0); next(); next();
    set_in(6'b11_11_0_1); s_rdata = 16'hAAAA; #1;
    check("ret_first", {m0_valid, m1_valid, m0_rdata}, {1'b1, 1'b0, 16'hAAAA});
    next();
    s_rdata = 16'h5555; #1;
    check("ret_second", {m0_valid, m1_valid, m1_rdata}, {1'b0, 1'b1, 16'h5555});
    next();

    // Lock: M0 read stalled 5 cycles while M1 requests
    for (int i = 0; i < 5; i++) begin
      set_in(6'b01_01_1_0); #1;
      check($sformatf("lock_hold%0d", i), {o_grant, m0_wait_req, m1_wait_req}, {2'b01, 1'b1, 1'b1});
      next();
    end
    set_in(6'b01_01_0_0); #1;
    check("lock_accept", {o_grant, m0_wait_req, m1_wait_req, s_rd_n}, {2'b01, 1'b0, 1'b1, 1'b0});
    next();
    set_in(6'b11_01_0_0); #1;
    check("lock_next", {o_grant, m1_wait_req, s_rd_n}, {2'b10, 1'b0, 1'b0});
    next();
    set_in(6'b11_11_0_1); #1;
    check("lock_ret0", {m0_valid, m1_valid}, 2'b10);
    next(); #1;
    check("lock_ret1", {m0_valid, m1_valid}, 2'b01);
    next();

    // FIFO full
    for (int i = 0; i < PEND; i++) begin
      set_in(6'b11_01_0_0); #1;
      check($sformatf("fill%0d", i), {m1_wait_req, s_rd_n}, 2'b00);
      next();
    end
    set_in(6'b11_01_0_0); #1;
    check("full_block", {o_grant, m1_wait_req, s_rd_n}, {2'b10, 1'b1, 1'b1});
    next();
    set_in(6'b10_11_0_0); #1;
    check("full_write", {o_grant, s_wr_n, m0_wait_req}, {2'b01, 1'b0, 1'b0});
    next();
    set_in(6'b11_01_0_1); #1;
    check("full_pop_cycle", {m1_wait_req, s_rd_n, m1_valid}, 3'b111);
    next();
    set_in(6'b11_01_0_0); #1;
    check("full_after_pop", {m1_wait_req, s_rd_n}, 2'b00);
    next();
    for (int i = 0; i < PEND; i++) begin
      set_in(6'b11_11_0_1); #1;
      check($sformatf("drain%0d", i), {m0_valid, m1_valid}, 2'b01);
      next();
    end
    set_in(6'b11_11_0_0); #1;
    check("full_no_error", o_error, 1'b0);

    // Orphan response
    set_in(6'b11_11_0_1); #1;
    check("orphan_valid", {m0_valid, m1_valid}, 2'b00);
    next();
    set_in(6'b11_11_0_0);
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("orphan_sticky%0d", i), o_error, 1'b1);
      next();
    end

    // Reset with reads pending
    for (int i = 0; i < 3; i++) begin set_in(6'b01_11_0_0); next(); end
    set_in(6'b11_11_0_0);
    reset_n = 1'b0; #1;
    check("mid_rst_grant", o_grant, 2'b00);
    check("mid_rst_error", o_error, 1'b0);
    next();
    reset_n = 1'b1;
    next();
    set_in(6'b11_11_0_1); #1;
    check("mid_rst_empty", {m0_valid, m1_valid}, 2'b00);
    next();
    set_in(6'b01_01_0_0); #1;
    check("mid_rst_tie", o_grant, 2'b01);
    next();

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        int r;
        r = $urandom_range(0, 99);
        rd_n[i] = 1'b1; wr_n[i] = 1'b1;
        if (r == 0)       begin rd_n[i] = 1'b0; wr_n[i] = 1'b0; end
        else if (r < 40)  rd_n[i] = 1'b0;
        else if (r < 65)  wr_n[i] = 1'b0;
        addr[i] = 22'($urandom);
        wdat[i] = 16'($urandom);
        be_n[i] = 2'($urandom);
      end
      s_wait_req = ($urandom_range(0, 3) == 0);
      s_valid    = ($urandom_range(0, 2) == 0);
      s_rdata    = 16'($urandom);
      #1;
      model_cycle();
      next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
